// File: rtl/rv32_instr_encoder.sv
// rtl/rv32_instr_encoder.sv - RV32I field-level request to instruction word encoder
//
// Purpose: packs field-level instruction requests into 32-bit RV32I words,
// stages them through one encode register and a 2-entry output FIFO, and
// pairs each emitted word with a running word address. Malformed requests
// are consumed, flagged on err_valid/err_code, and never emitted.
//
// Optional feature: define RANGE_CHECK_EN to reject out-of-range immediates
// (code 3) and odd branch/jump offsets (code 4). Without it, such immediates
// are truncated into the encoded fields.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   in_valid/in_ready           request handshake
//   in_class, in_funct3, in_alt request class, funct3, funct7[5] select
//   in_rd, in_rs1, in_rs2       register indices
//   in_imm                      byte-offset immediate (LUI/AUIPC: final value)
//   addr_load, addr_value       synchronous load of the word address
//   out_valid/out_ready         output handshake
//   out_instr, out_addr         head word and its address
//   err_valid, err_code         one-cycle error pulse and sticky error code
`timescale 1ns/1ps

module rv32_instr_encoder #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter logic [31:0] ADDR_STEP = 32'd4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_class,
   input  logic [2:0]  in_funct3,
   input  logic        in_alt,
   input  logic [4:0]  in_rd,
   input  logic [4:0]  in_rs1,
   input  logic [4:0]  in_rs2,
   input  logic [31:0] in_imm,
   input  logic        addr_load,
   input  logic [31:0] addr_value,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_addr,
   output logic        err_valid,
   output logic [2:0]  err_code
);

   localparam logic [3:0] CL_ALUI   = 4'd0;
   localparam logic [3:0] CL_ALU    = 4'd1;
   localparam logic [3:0] CL_LOAD   = 4'd2;
   localparam logic [3:0] CL_STORE  = 4'd3;
   localparam logic [3:0] CL_BRANCH = 4'd4;
   localparam logic [3:0] CL_JALR   = 4'd5;
   localparam logic [3:0] CL_JAL    = 4'd6;
   localparam logic [3:0] CL_LUI    = 4'd7;
   localparam logic [3:0] CL_AUIPC  = 4'd8;

   localparam logic [6:0] OP_ALUI   = 7'b0010011;
   localparam logic [6:0] OP_ALU    = 7'b0110011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   // Encode stage, FIFO (f0 is the head) and address/error registers
   logic        stg_valid_q, stg_valid_d;
   logic [31:0] stg_word_q, stg_word_d;
   logic [31:0] f0_q, f0_d, f1_q, f1_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic        err_valid_q, err_valid_d;
   logic [2:0]  err_code_q, err_code_d;

   logic [31:0] word;
   logic [2:0]  code;
   logic        shamt_op, alu_alt, accept, push, pop;
   logic [11:0] alui_imm;
   logic [2:0]  occupancy;

   assign shamt_op = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);
   assign alu_alt  = in_alt && ((in_funct3 == 3'b000) || (in_funct3 == 3'b101));
   assign alui_imm = shamt_op ? {1'b0, in_alt & (in_funct3 == 3'b101), 5'b0, in_imm[4:0]}
                              : in_imm[11:0];

`ifdef RANGE_CHECK_EN
   // A signed N-bit value has all bits from N-1 upward equal
   logic fit12, fit13, fit21;
   assign fit12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
   assign fit13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
   assign fit21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);
`endif

   always_comb begin
      word = 32'b0;
      code = 3'd0;
      case (in_class)
         CL_ALUI: begin
            word = {alui_imm, in_rs1, in_funct3, in_rd, OP_ALUI};
            if (in_funct3 == 3'b001 && in_alt) code = 3'd2;
         end
         CL_ALU: word = {1'b0, alu_alt, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, OP_ALU};
         CL_LOAD: begin
            word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
            case (in_funct3)
               3'b000, 3'b001, 3'b010, 3'b100, 3'b101: code = 3'd0;
               default: code = 3'd2;
            endcase
         end
         CL_STORE: begin
            word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
            if (in_funct3[2] || (in_funct3[1:0] == 2'b11)) code = 3'd2;
         end
         CL_BRANCH: begin
            word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], OP_BRANCH};
            if (in_funct3[2:1] == 2'b01) code = 3'd2;
         end
         CL_JALR:  word = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_JALR};
         CL_JAL:   word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
         CL_LUI:   word = {in_imm[31:12], in_rd, OP_LUI};
         CL_AUIPC: word = {in_imm[31:12], in_rd, OP_AUIPC};
         default:  code = 3'd1;
      endcase
`ifdef RANGE_CHECK_EN
      // Range checks only apply once class and funct3 are known good
      if (code == 3'd0) begin
         case (in_class)
            CL_ALUI: if (shamt_op ? (|in_imm[31:5]) : !fit12) code = 3'd3;
            CL_LOAD, CL_STORE, CL_JALR: if (!fit12) code = 3'd3;
            CL_BRANCH: begin
               if (!fit13) code = 3'd3;
               else if (in_imm[0]) code = 3'd4;
            end
            CL_JAL: begin
               if (!fit21) code = 3'd3;
               else if (in_imm[0]) code = 3'd4;
            end
            CL_LUI, CL_AUIPC: if (|in_imm[11:0]) code = 3'd3;
            default: code = code;
         endcase
      end
`endif
   end

   // The encode stage counts toward occupancy so a staged word always has a slot
   assign occupancy = {1'b0, cnt_q} + {2'b0, stg_valid_q};
   assign in_ready  = (occupancy < 3'd2);
   assign accept    = in_valid && in_ready;
   assign push      = stg_valid_q;
   assign pop       = (cnt_q != 2'd0) && out_ready;

   always_comb begin
      stg_valid_d = accept && (code == 3'd0);
      stg_word_d  = word;
      err_valid_d = accept && (code != 3'd0);
      err_code_d  = err_valid_d ? code : err_code_q;
      f0_d        = f0_q;
      f1_d        = f1_q;
      cnt_d       = cnt_q;
      case ({push, pop})
         2'b10: begin
            if (cnt_q == 2'd0) f0_d = stg_word_q;
            else               f1_d = stg_word_q;
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            f0_d  = f1_q;
            cnt_d = cnt_q - 2'd1;
         end
         2'b11: begin
            if (cnt_q == 2'd1) begin
               f0_d = stg_word_q;
            end else begin
               f0_d = f1_q;
               f1_d = stg_word_q;
            end
         end
         default: cnt_d = cnt_q;
      endcase
      if (addr_load)  addr_d = addr_value;
      else if (pop)   addr_d = addr_q + ADDR_STEP;
      else            addr_d = addr_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stg_valid_q <= 1'b0;
         stg_word_q  <= 32'b0;
         f0_q        <= 32'b0;
         f1_q        <= 32'b0;
         cnt_q       <= 2'd0;
         addr_q      <= BASE_ADDR;
         err_valid_q <= 1'b0;
         err_code_q  <= 3'd0;
      end else begin
         stg_valid_q <= stg_valid_d;
         stg_word_q  <= stg_word_d;
         f0_q        <= f0_d;
         f1_q        <= f1_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         err_valid_q <= err_valid_d;
         err_code_q  <= err_code_d;
      end
   end

   assign out_valid = (cnt_q != 2'd0);
   assign out_instr = out_valid ? f0_q : 32'b0;
   assign out_addr  = addr_q;
   assign err_valid = err_valid_q;
   assign err_code  = err_code_q;

endmodule

// File: doc/rv32_instr_encoder.md
Name: rv32_instr_encoder

Overview:
- Inverse of the core's instruction decoder: accepts field-level instruction requests (class, funct3, alt bit, rd/rs1/rs2, immediate) and packs them into 32-bit RV32I instruction words.
- Feeds the instruction-memory loader and self-test generators through valid/ready handshakes on both sides.
- Contains a registered encode stage, a 2-entry output FIFO and a word-address counter.
- Malformed requests are consumed and flagged; they are never emitted.

Parameters:
- BASE_ADDR, 32'h0000_0000: value loaded into out_addr at reset.
- ADDR_STEP, 4: out_addr increment per emitted word.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_class  in  4  0 ALUI, 1 ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 JALR, 6 JAL, 7 LUI, 8 AUIPC; 9-15 illegal.
- in_funct3  in  3  funct3 field.
- in_alt  in  1  funct7[5] select for sub/sra/srai/srl variants.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_imm  in  32  immediate, byte offset; LUI/AUIPC supply the final value, of which imm[31:12] is used.
- addr_load  in  1  synchronous load of out_addr.
- addr_value  in  32  value for addr_load.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer ready.
- out_instr  out  32  encoded word at FIFO head.
- out_addr  out  32  address paired with the head word.
- err_valid  out  1  one-cycle error pulse.
- err_code  out  3  1 bad class, 2 bad funct3, 3 imm out of range, 4 misaligned offset; holds its last value between pulses.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FIFO emptied; out_valid=0, out_instr=0.
  - in_ready=1 from the first cycle after reset.
  - out_addr=BASE_ADDR; err_valid=0, err_code=0.
  - Any in-flight request is discarded.
- in_ready = (FIFO count < 2), derived from registered state only; no combinational path from out_ready.
- Latency: request accepted at edge N appears with out_valid=1 after edge N+1 if the FIFO was empty; at most one word per cycle.
- Simultaneous push and pop at count 2 is not permitted (in_ready=0). At count 1 it keeps count at 1.
- out_addr advances by ADDR_STEP on each out_valid && out_ready handshake.
  - addr_load has priority over the increment in the same cycle.
  - Wrap-around modulo 2^32.
- Field placement (opcode in [6:0]):
  - ALUI 0010011: {imm[11:0],rs1,f3,rd,op}.
    - f3=001/101: {1'b0,alt&(f3==101),5'b0,imm[4:0]} replaces imm[11:0].
  - ALU 0110011: {1'b0,alt,5'b0,rs2,rs1,f3,rd,op}; alt forced 0 unless f3 is 000 or 101.
  - LOAD 0000011: I-format.
  - STORE 0100011: {imm[11:5],rs2,rs1,f3,imm[4:0],op}.
  - BRANCH 1100011: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}.
  - JALR 1100111: I-format with f3 forced 000.
  - JAL 1101111: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
  - LUI 0110111 and AUIPC 0010111: {imm[31:12],rd,op}.
  - Unused register fields are not encoded.
- Always-on checks, in priority order:
  - class 9-15 -> code 1.
  - funct3 illegal -> code 2:
    - LOAD f3 not in {000,001,010,100,101};
    - STORE f3 not in {000,001,010};
    - BRANCH f3 in {010,011};
    - ALUI f3=001 with alt=1.
- On error:
  - the request is consumed (handshake completes) but not pushed;
  - err_valid pulses the cycle after acceptance;
  - out_addr is unchanged.
- Back-to-back errors produce back-to-back pulses.

Optional Feature:
- RANGE_CHECK_EN defined: additional checks, applied after codes 1-2.
  - I/S imm must be signed 12-bit -> else code 3.
  - Shamt must satisfy imm[31:5]==0 -> else code 3.
  - BRANCH imm must be signed 13-bit and JAL imm signed 21-bit -> else code 3; with imm[0]==1 -> code 4 (range is checked first).
  - LUI/AUIPC imm[11:0]!=0 -> code 3.
- Undefined: out-of-range bits are silently truncated and the word is emitted; codes 3/4 never occur.

Test Plan:
- ALUI f3=000 rd=1 rs1=0 imm=5 -> out_instr=0x00500093, out_addr=BASE_ADDR, out_valid one cycle after acceptance.
- ALU f3=000 alt=1 rd=3 rs1=1 rs2=2 -> 0x402081B3; BRANCH f3=000 rs1=1 rs2=2 imm=8 -> 0x00208463, out_addr=BASE+4.
- JAL rd=1 imm=0x800 -> 0x001000EF; LUI rd=5 imm=0x12345000 -> 0x123452B7.
- out_ready=0, three back-to-back requests -> in_ready drops after the 2nd; the 3rd waits; releasing out_ready drains in order with addresses +0/+4/+8.
- Error cases:
  - class=12 -> err_valid pulse, err_code=1, no output.
  - With RANGE_CHECK_EN, ALUI imm=2048 -> err_code=3.
  - Without RANGE_CHECK_EN, ALUI imm=2048 -> 0x80000013 emitted.
- rst_n=0 with two words queued and addr_load asserted -> out_valid=0, out_addr=BASE_ADDR, in_ready=1 in the next cycle.
